kmouse_packet_engine: RTL and testbench

KMOUSE_PACKET_ENGINE -- requirements
Module: kmouse_packet_engine

---
 rtl/kmouse_packet_engine.sv | 177 +++++++++++++++++
 tb/tb_kmouse_packet_engine.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kmouse_packet_engine.sv
// kmouse_packet_engine: PS/2 mouse packet assembler with X/Y/wheel tracking.
// Macro KMOUSE_WHEEL_EN adds 4-byte IntelliMouse packets and the wheel counter.
module kmouse_packet_engine #(
  parameter int          COORD_W     = 8,
  parameter int          SCALE_SHIFT = 0,
  parameter int          SATURATE    = 0,
  parameter logic [23:0] TIMEOUT     = 24'd500000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         data,
  input  logic               data_valid,
  input  logic               wheel_mode,
  input  logic               coord_clear,
  output logic [COORD_W-1:0] kmouse_x,
  output logic [COORD_W-1:0] kmouse_y,
  output logic [7:0]         kmouse_buttons,
  output logic               packet_done,
  output logic [7:0]         err_count
);

`ifdef KMOUSE_WHEEL_EN
  typedef enum logic [1:0] {B0, B1, B2, B3} state_t;
`else
  typedef enum logic [1:0] {B0, B1, B2} state_t;
`endif

  state_t               r_state;
  logic [23:0]          r_idle;
  // {ovf_y, ovf_x, sign_y, sign_x, buttons[2:0]} of the header byte
  logic [6:0]           r_hdr;
  logic [7:0]           r_b1;
  logic [COORD_W-1:0]   r_x;
  logic [COORD_W-1:0]   r_y;
  logic [2:0]           r_btn;
  logic                 r_done;
  logic [7:0]           r_err;
  logic [3:0]           w_wheel_nib;

  state_t               w_st;
  logic                 w_timeout;
  logic                 w_sync_err;
  logic                 w_last;
  logic                 w_ovf;
  logic [7:0]           w_dy_byte;
  logic signed [COORD_W:0] w_dx;
  logic signed [COORD_W:0] w_dy;
  logic [1:0]           w_err_inc;
  logic [8:0]           w_err_sum;

  function automatic logic signed [COORD_W:0] f_delta(
    input logic s, input logic [7:0] b);
    logic signed [8:0] v;
    v = $signed({s, b}) >>> SCALE_SHIFT;
    return (COORD_W+1)'(v);
  endfunction

  function automatic logic [COORD_W-1:0] f_move(
    input logic [COORD_W-1:0] p, input logic signed [COORD_W:0] d);
    logic signed [COORD_W+1:0] s;
    s = $signed({2'b00, p}) + (COORD_W+2)'(d);
    if (SATURATE != 0) begin
      if (s < 0)
        return '0;
      if (s > $signed({2'b00, {COORD_W{1'b1}}}))
        return '1;
    end
    return s[COORD_W-1:0];
  endfunction

  // a timed-out packet is dropped and a coincident byte is seen from B0
  assign w_timeout  = (r_state != B0) && (r_idle == TIMEOUT - 24'd1);
  assign w_st       = w_timeout ? B0 : r_state;
  assign w_sync_err = data_valid && (w_st == B0) && !data[3];
  assign w_ovf      = r_hdr[6] | r_hdr[5];

`ifdef KMOUSE_WHEEL_EN
  logic       r_len4;
  logic [7:0] r_b2;
  logic [3:0] r_wheel;
  assign w_last = data_valid &&
    (((w_st == B2) && !r_len4) || (w_st == B3));
  assign w_dy_byte   = (w_st == B3) ? r_b2 : data;
  assign w_wheel_nib = r_wheel;

  // wheel packet length latch, third byte and wheel counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len4  <= 1'b0;
      r_b2    <= '0;
      r_wheel <= '0;
    end else begin
      if (data_valid && (w_st == B0) && data[3])
        r_len4 <= wheel_mode;
      if (data_valid && (w_st == B2))
        r_b2 <= data;
      if (coord_clear)
        r_wheel <= '0;
      else if (w_last && (w_st == B3))
        r_wheel <= r_wheel + data[3:0];
    end
  end
`else
  logic w_unused_wheel_mode;
  assign w_unused_wheel_mode = wheel_mode;
  assign w_last      = data_valid && (w_st == B2);
  assign w_dy_byte   = data;
  assign w_wheel_nib = 4'hF;
`endif

  assign w_dx = w_ovf ? '0 : f_delta(r_hdr[3], r_b1);
  assign w_dy = w_ovf ? '0 : f_delta(r_hdr[4], w_dy_byte);

  assign w_err_inc = {1'b0, w_timeout} + {1'b0, w_sync_err} +
                     {1'b0, w_last & w_ovf};
  assign w_err_sum = {1'b0, r_err} + {7'd0, w_err_inc};

  // packet FSM, idle timer, position commit and error counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= B0;
      r_idle  <= '0;
      r_hdr   <= '0;
      r_b1    <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_btn   <= 3'b111;
      r_done  <= 1'b0;
      r_err   <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
      if (data_valid || w_timeout || (r_state == B0))
        r_idle <= '0;
      else
        r_idle <= r_idle + 24'd1;
      if (w_timeout)
        r_state <= B0;
      if (data_valid) begin
        unique case (w_st)
          B0: if (data[3]) begin
            r_hdr   <= {data[7:4], data[2:0]};
            r_state <= B1;
          end
          B1: begin
            r_b1    <= data;
            r_state <= B2;
          end
`ifdef KMOUSE_WHEEL_EN
          B2: r_state <= r_len4 ? B3 : B0;
          B3: r_state <= B0;
`else
          B2: r_state <= B0;
`endif
          default: r_state <= B0;
        endcase
      end
      if (w_last) begin
        r_x    <= f_move(r_x, w_dx);
        r_y    <= f_move(r_y, w_dy);
        r_btn  <= ~r_hdr[2:0];
        r_done <= 1'b1;
      end
      if (coord_clear) begin
        r_x <= '0;
        r_y <= '0;
      end
    end
  end

  assign kmouse_x       = r_x;
  assign kmouse_y       = r_y;
  assign kmouse_buttons = {w_wheel_nib, 1'b1, r_btn};
  assign packet_done    = r_done;
  assign err_count      = r_err;

endmodule

// File: tb/tb_kmouse_packet_engine.sv
// tb_kmouse_packet_engine: directed bench for kmouse_packet_engine.
// Three parameter sets run in lockstep against a packet-level model.
module tb_kmouse_packet_engine;

`ifdef KMOUSE_WHEEL_EN
  localparam bit WHEEL = 1'b1;
`else
  localparam bit WHEEL = 1'b0;
`endif
  localparam int TO = 100;
  localparam int BTN0 = WHEEL ? 8'h0F : 8'hFF;

  int P_CW[3]  = '{8, 8, 10};
  int P_SH[3]  = '{0, 0, 1};
  int P_SAT[3] = '{0, 1, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dv = 1'b0;
  logic wm = 1'b0;
  logic clr = 1'b0;
  logic [7:0] dat = 8'h00;

  logic [7:0] xa, ya, xb, yb;
  logic [9:0] xc, yc;
  logic [7:0] ba, bb, bc, ea, eb, ec;
  logic da, db, dc;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  int mx[3], my[3], mwh[3], mbt[3], merr[3];
  int mdn[3], mcnt[3], mlen[3], midle[3];
  logic [7:0] mb[3][4];

  always #5 clk = ~clk;

  kmouse_packet_engine #(.COORD_W(8), .SCALE_SHIFT(0), .SATURATE(0),
    .TIMEOUT(24'd100)) u_a (
    .clk(clk), .rst(rst), .data(dat), .data_valid(dv),
    .wheel_mode(wm), .coord_clear(clr), .kmouse_x(xa), .kmouse_y(ya),
    .kmouse_buttons(ba), .packet_done(da), .err_count(ea));

  kmouse_packet_engine #(.COORD_W(8), .SCALE_SHIFT(0), .SATURATE(1),
    .TIMEOUT(24'd100)) u_b (
    .clk(clk), .rst(rst), .data(dat), .data_valid(dv),
    .wheel_mode(wm), .coord_clear(clr), .kmouse_x(xb), .kmouse_y(yb),
    .kmouse_buttons(bb), .packet_done(db), .err_count(eb));

  kmouse_packet_engine #(.COORD_W(10), .SCALE_SHIFT(1), .SATURATE(1),
    .TIMEOUT(24'd100)) u_c (
    .clk(clk), .rst(rst), .data(dat), .data_valid(dv),
    .wheel_mode(wm), .coord_clear(clr), .kmouse_x(xc), .kmouse_y(yc),
    .kmouse_buttons(bc), .packet_done(dc), .err_count(ec));

  function automatic int dlt(input logic s, input logic [7:0] b,
                             input int sh);
    int v;
    v = s ? int'(b) - 256 : int'(b);
    return v >>> sh;
  endfunction

  function automatic int mv(input int p, input int d, input int k);
    int n, top;
    n = p + d;
    top = (1 << P_CW[k]) - 1;
    if (P_SAT[k] != 0) begin
      if (n < 0) return 0;
      if (n > top) return top;
      return n;
    end
    return n & top;
  endfunction

  task automatic mcommit(input int k, inout int e);
    int ovf, dx, dy;
    ovf = (mb[k][0][7] | mb[k][0][6]) ? 1 : 0;
    dx = ovf ? 0 : dlt(mb[k][0][4], mb[k][1], P_SH[k]);
    dy = ovf ? 0 : dlt(mb[k][0][5], mb[k][2], P_SH[k]);
    mx[k] = mv(mx[k], dx, k);
    my[k] = mv(my[k], dy, k);
    mbt[k] = 7 - int'(mb[k][0][2:0]);
    if (mlen[k] == 4)
      mwh[k] = (mwh[k] + int'(mb[k][3][3:0])) & 15;
    e += ovf;
    mdn[k] = 1;
  endtask

  task automatic mstep(input int k);
    int e;
    e = 0;
    mdn[k] = 0;
    if (rst) begin
      mx[k] = 0; my[k] = 0; mwh[k] = 0; mbt[k] = 7;
      merr[k] = 0; mcnt[k] = 0; midle[k] = 0; mlen[k] = 3;
      return;
    end
    if (mcnt[k] > 0 && midle[k] + 1 >= TO) begin
      mcnt[k] = 0;
      midle[k] = 0;
      e++;
    end
    if (dv) begin
      midle[k] = 0;
      if (mcnt[k] == 0) begin
        if (!dat[3]) e++;
        else begin
          mb[k][0] = dat;
          mcnt[k] = 1;
          mlen[k] = (WHEEL && wm) ? 4 : 3;
        end
      end else begin
        mb[k][mcnt[k]] = dat;
        mcnt[k]++;
        if (mcnt[k] == mlen[k]) begin
          mcommit(k, e);
          mcnt[k] = 0;
        end
      end
    end else if (mcnt[k] > 0) begin
      midle[k]++;
    end
    if (clr) begin
      mx[k] = 0; my[k] = 0; mwh[k] = 0;
    end
    merr[k] = (merr[k] + e > 255) ? 255 : merr[k] + e;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, exp);
    end
  endtask

  task automatic cmp(input int k, input int ax, input int ay,
                     input int ab, input int ad, input int ae);
    int eb;
    eb = ((WHEEL ? mwh[k] : 15) << 4) | 8 | mbt[k];
    chk($sformatf("x%0d", k), ax, mx[k]);
    chk($sformatf("y%0d", k), ay, my[k]);
    chk($sformatf("btn%0d", k), ab, eb);
    chk($sformatf("done%0d", k), ad, mdn[k]);
    chk($sformatf("err%0d", k), ae, merr[k]);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, int'(xa), int'(ya), int'(ba), int'(da), int'(ea));
      cmp(1, int'(xb), int'(yb), int'(bb), int'(db), int'(eb));
      cmp(2, int'(xc), int'(yc), int'(bc), int'(dc), int'(ec));
    end
  end

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++) mstep(k);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic c = 1'b0);
    dv = 1'b1; dat = b; clr = c;
    tick();
    dv = 1'b0; clr = 1'b0;
  endtask

  task automatic pkt(input logic [7:0] b0, input logic [7:0] b1,
                     input logic [7:0] b2);
    send(b0); send(b1); send(b2);
  endtask

  task automatic clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    tick(); tick();
    chk_en = 1'b1;
    tick();
    chk("rst_x", int'(xa), 0);
    chk("rst_btn", int'(ba), BTN0);
    chk("rst_err", int'(ea), 0);
    rst = 1'b0;
    tick();

    pkt(8'h08, 8'h05, 8'h03);
    chk("p1_done", int'(da), 1);
    chk("p1_x", int'(xa), 5);
    chk("p1_y", int'(ya), 3);
    chk("p1_btn", int'(ba), BTN0);
    tick();
    chk("p1_done_low", int'(da), 0);

    clear();
    pkt(8'h08, 8'hFA, 8'h00);
    chk("x250", int'(xa), 250);
    pkt(8'h08, 8'h0A, 8'h00);
    chk("wrap_x", int'(xa), 4);
    chk("sat_x", int'(xb), 255);

    clear();
    send(8'h00);
    pkt(8'h08, 8'h01, 8'h01);
    chk("sync_err", int'(ea), 1);
    chk("sync_x", int'(xa), 1);
    chk("sync_y", int'(ya), 1);

    pkt(8'h48, 8'h05, 8'h03);
    chk("ovf_done", int'(da), 1);
    chk("ovf_x", int'(xa), 1);
    chk("ovf_y", int'(ya), 1);
    chk("ovf_err", int'(ea), 2);

    clear();
    send(8'h08); send(8'h05);
    repeat (TO) tick();
    pkt(8'h08, 8'h02, 8'h02);
    chk("to_err", int'(ea), 3);
    chk("to_x", int'(xa), 2);
    chk("to_y", int'(ya), 2);

    send(8'h08); send(8'h05);
    repeat (TO - 1) tick();
    pkt(8'h08, 8'h02, 8'h02);
    chk("to_coin_err", int'(ea), 4);
    chk("to_coin_x", int'(xa), 4);

    send(8'h08); send(8'h05);
    repeat (TO - 1) tick();
    send(8'h00);
    chk("to_sync_err", int'(ea), 6);

    pkt(8'h38, 8'hFE, 8'hFD);
    chk("neg_x", int'(xa), 2);
    chk("neg_y", int'(ya), 1);
    pkt(8'h38, 8'hF0, 8'hF0);
    chk("neg_wrap_x", int'(xa), 242);
    chk("neg_wrap_y", int'(ya), 241);
    chk("neg_sat_x", int'(xb), 0);
    chk("neg_sat_y", int'(yb), 0);

    send(8'h09); send(8'h05); send(8'h05, 1'b1);
    chk("clr_done", int'(da), 1);
    chk("clr_x", int'(xa), 0);
    chk("clr_btn", int'(ba), WHEEL ? 8'h0E : 8'hFE);

    send(8'h08); send(8'h05);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_done", int'(da), 0);
    chk("mid_rst_err", int'(ea), 0);
    pkt(8'h08, 8'h07, 8'h07);
    chk("after_rst_x", int'(xa), 7);

    wm = 1'b1;
    pkt(8'h09, 8'h00, 8'h00);
    send(8'h0F);
    chk("wheel_btn", int'(ba), 8'hFE);
    wm = 1'b0;
    repeat (TO + 2) tick();

    wm = 1'b1;
    send(8'h08);
    wm = 1'b0;
    pkt(8'h00, 8'h00, 8'h01);
    chk("wm_latch_btn", int'(ba), BTN0);
    repeat (TO + 2) tick();

    for (int i = 0; i < 260; i++) begin
      send(8'h00);
      tick();
    end
    chk("err_sat", int'(ea), 255);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
